// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 32-bit SRAM wrapper port between the host
// register path and the engine. Each 64-bit access is split into two beats,
// low word first, and each beat is paced by the wrapper's sram_state.
module sram_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        host_req,
  input  logic        host_write,
  input  logic [8:0]  host_addr,
  input  logic [63:0] host_wdata,
  output logic [63:0] host_rdata,
  output logic        host_done,
  output logic        host_err,
  input  logic        eng_req,
  input  logic        eng_write,
  input  logic [8:0]  eng_addr,
  input  logic [63:0] eng_wdata,
  output logic [63:0] eng_rdata,
  output logic        eng_done,
  output logic        eng_err,
  output logic [9:0]  addr,
  output logic        ren,
  output logic        wen,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [1:0]  sram_state,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE
  } state_t;

  localparam logic [1:0] ST_FREE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b10;
  localparam logic [1:0] ST_ERROR  = 2'b11;
  // The counter is compared before its increment, so the last permitted
  // wait cycle is the one where it still holds TIMEOUT-1.
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        gnt_eng;
  logic        last_eng;
  logic        err_flag;
  logic [7:0]  cnt;
  logic        take;
  logic        pick_eng;
  logic        beat_ok;
  logic        beat_err;
  logic        op_write;
  logic [8:0]  op_addr;
  logic [63:0] op_wdata;
  logic [63:0] res;
  logic [63:0] rd_word;

  // On a tie the requester not served last wins; otherwise whoever asks.
  assign pick_eng = (host_req && eng_req) ? ~last_eng : eng_req;
  // The high half comes straight off the bus when the last beat completes.
  assign rd_word  = {(beat_ok ? rdata : res[63:32]), res[31:0]};

  // Next-state and all strobe/pulse outputs of the beat sequencer.
  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    beat_ok   = 1'b0;
    beat_err  = 1'b0;
    ren       = 1'b0;
    wen       = 1'b0;
    addr      = '0;
    wdata     = '0;
    host_done = 1'b0;
    host_err  = 1'b0;
    eng_done  = 1'b0;
    eng_err   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (host_req || eng_req) begin
          take     = 1'b1;
          state_nx = ISSUE_LO;
        end
      end
      ISSUE_LO, ISSUE_HI: begin
        if (sram_state == ST_FREE) begin
          ren      = ~op_write;
          wen      = op_write;
          addr     = {op_addr, (state == ISSUE_HI)};
          wdata    = (state == ISSUE_HI) ? op_wdata[63:32] : op_wdata[31:0];
          state_nx = (state == ISSUE_HI) ? WAIT_HI : WAIT_LO;
        end
      end
      WAIT_LO, WAIT_HI: begin
        if (sram_state == ST_ACCESS) begin
          beat_ok = 1'b1;
        end else if (sram_state == ST_ERROR || cnt == TO_LAST) begin
          beat_err = 1'b1;
        end
        // An errored beat still moves on, so the high beat is always issued.
        if (beat_ok || beat_err) begin
          state_nx = (state == WAIT_HI) ? DONE : ISSUE_HI;
        end
      end
      DONE: begin
        host_done = ~gnt_eng;
        host_err  = ~gnt_eng & err_flag;
        eng_done  = gnt_eng;
        eng_err   = gnt_eng & err_flag;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state, grant history, timeout counter and returned read data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      gnt_eng    <= 1'b0;
      last_eng   <= 1'b1;
      err_flag   <= 1'b0;
      cnt        <= '0;
      host_rdata <= '0;
      eng_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (take) gnt_eng <= pick_eng;
      if (state == ISSUE_LO || state == ISSUE_HI) begin
        cnt <= '0;
      end else if (state == WAIT_LO || state == WAIT_HI) begin
        cnt <= cnt + 8'd1;
      end
      if (beat_err) begin
        err_flag <= 1'b1;
      end else if (state == DONE) begin
        err_flag <= 1'b0;
      end
      if (state == DONE) last_eng <= gnt_eng;
      // Loaded as the last beat completes so it is already valid during DONE.
      if (state == WAIT_HI && (beat_ok || beat_err) && !op_write) begin
        if (gnt_eng) eng_rdata  <= rd_word;
        else         host_rdata <= rd_word;
      end
    end
  end

  // Transaction fields are sampled once at grant; read beats fill the result.
  always_ff @(posedge clk) begin
    if (take) begin
      op_write <= pick_eng ? eng_write : host_write;
      op_addr  <= pick_eng ? eng_addr  : host_addr;
      op_wdata <= pick_eng ? eng_wdata : host_wdata;
    end
    if (state == WAIT_LO && beat_ok && !op_write) res[31:0]  <= rdata;
    if (state == WAIT_HI && beat_ok && !op_write) res[63:32] <= rdata;
  end

endmodule
